mips_cpu_muldiv_ctrl: RTL and testbench
=======================================

# mips_cpu_muldiv_ctrl

Sequencer for the MIPS Hi/Lo register pair and its multiply/divide datapath, used by `mips_cpu_harvard` in the execute stage. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests and performs multiply and divide iteratively, one bit per cycle. It owns Hi and Lo, and drives `busy` so the CPU stalls any MFHI/MFLO or new mul/div request until the result is committed.

## Interface
- Parameters: none. Width is fixed at 32 bits.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request strobe, sampled at the rising edge.
- `op` in 3: operation code.
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - 6 and 7 are ignored.
- `a` in 32: rs operand; it is the MTHI/MTLO source.
- `b` in 32: rt operand.
- `busy` out 1: high while an iterative operation is in flight.
- `done` out 1: one-cycle pulse after Hi/Lo are committed.
- `hi` out 32: architectural Hi register.
- `lo` out 32: architectural Lo register.

## Operation
- States:
  - IDLE: waiting for a request.
  - MUL: multiply iteration.
  - DIV: divide iteration.
  - FIX: sign correction and commit.
- Reset, asynchronous: state=IDLE, iteration counter=0, `hi`=`lo`=0, `busy`=0, `done`=0. Any in-flight operation is discarded.
- IDLE with `start`=1:
  - MTHI: `hi`<=`a`. MTLO: `lo`<=`a`.
  - Both stay in IDLE, never raise `busy`, and pulse `done` in the next cycle.
  - MULT/MULTU: latch operands → MUL, counter=0.
  - DIV/DIVU: latch operands → DIV, counter=0.
  - Signed ops latch operand magnitudes plus a sign flag for the result.
  - Unsigned ops latch the raw operands.
- MUL, 64-bit shift-add:
  - Each cycle, if multiplier bit 0 = 1, add the multiplicand into the upper half of the 64-bit accumulator.
  - Then shift accumulator and multiplier right by 1.
  - After 32 iterations → FIX.
- DIV, restoring, 32 iterations:
  - Shift {remainder, quotient} left by 1.
  - If remainder ≥ divisor: subtract, set quotient bit 0.
  - After 32 iterations → FIX.
- FIX:
  - MULT: if sign(a)≠sign(b), negate the 64-bit product.
  - DIV: quotient negated if sign(a)≠sign(b); remainder takes sign(a).
  - Commit `hi`=product[63:32] or remainder, `lo`=product[31:0] or quotient.
  - → IDLE, `done`=1 for one cycle.
- Divide by zero (`b`=0, DIV or DIVU):
  - Iterations still run; result is forced to `hi`=`a`, `lo`=32'hFFFFFFFF.
  - No sign fix; latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0 (natural wrap, no trap).
- `start` while `busy`=1 is ignored, including MTHI/MTLO. The CPU is responsible for holding the request.
- `hi`/`lo` hold their old values throughout MUL/DIV/FIX. They change only on a commit edge, a MTHI/MTLO edge, or reset.
- Operands are latched at acceptance, so later changes on `a`/`b`/`op` have no effect.

## Timing
- Acceptance at edge k (IDLE, `start`=1, mul/div op):
  - `busy`=1 from after edge k through edge k+33.
  - Iterations run on edges k+1..k+32.
  - FIX commit at edge k+33.
  - `hi`/`lo` are valid and `done`=1 in the cycle after edge k+33; `busy`=0 in that same cycle.
- A new request may be accepted at edge k+34, the cycle in which `done` is high. Back-to-back throughput is therefore one op per 34 cycles.
- MTHI/MTLO at edge k: register updated at edge k, `done`=1 in the cycle after.
- `busy` is a registered output, equal to (state≠IDLE). No combinational path from `start` to `busy`.
- `done` is registered and cleared on the edge after it asserts.

## Test plan
- **MULT signed:** `a`=0xFFFFFFFD (−3), `b`=5 → `busy` high for 33 cycles; `done` in cycle 34; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- **MULTU:** `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **DIV signed:** `a`=0xFFFFFFF9 (−7), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **DIVU:**
  - `a`=100, `b`=7 → `lo`=14, `hi`=2.
  - Then DIVU `a`=0x1234, `b`=0 → `hi`=0x1234, `lo`=0xFFFFFFFF after the same 33-cycle latency.
- **Busy rejection and moves:**
  - Start MULT 2×3; pulse MTHI `a`=0xDEAD at cycle 10 → ignored; `hi`=0, `lo`=6 at done.
  - Then MTLO `a`=0xBEEF → `lo`=0xBEEF next cycle; `busy` stays 0.
- **Reset mid-operation:**
  - With `hi`=0x1, `lo`=0x2 preloaded via MTHI/MTLO, start DIVU; assert `reset` at cycle 15 between clock edges.
  - Required: `busy`=0, `done`=0, `hi`=`lo`=0 immediately.
  - After release, a MULTU 4×4 yields `lo`=16, `hi`=0 with normal latency.

Source files
------------

// File: rtl/mips_cpu_muldiv_ctrl.sv
// Hi/Lo register pair with iterative 32-bit multiply/divide sequencer.
// One bit per cycle: MULT/MULTU shift-add, DIV/DIVU restoring; MTHI/MTLO write directly.
module mips_cpu_muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
    OP_MTHI = 3'd4, OP_MTLO  = 3'd5
  } op_t;

  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic [63:0] acc, acc_nx;
  logic [31:0] opa, opa_nx;   // multiplicand / dividend magnitude
  logic [31:0] opb, opb_nx;   // multiplier / divisor magnitude
  logic        neg_res, neg_res_nx, neg_rem, neg_rem_nx, is_div, is_div_nx;
  logic [31:0] hi_nx, lo_nx;
  logic        busy_nx, done_nx;

  logic        op_mul, op_div, op_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, rem_sh, rem_sub;
  logic [63:0] prod;

  assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed & a[31];
  assign b_neg     = op_signed & b[31];
  assign a_mag     = a_neg ? 32'd0 - a : a;
  assign b_mag     = b_neg ? 32'd0 - b : b;

  // Carry out of the upper-half add is kept and shifted into acc[63].
  assign mul_sum = {1'b0, acc[63:32]} + (opb[0] ? {1'b0, opa} : 33'd0);
  // Shifted remainder needs 33 bits since it can exceed a 32-bit divisor.
  assign rem_sh  = acc[63:31];
  assign rem_sub = rem_sh - {1'b0, opb};
  assign prod    = neg_res ? 64'd0 - acc : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start && op_mul)      state_nx = S_MUL;
        else if (start && op_div) state_nx = S_DIV;
      end
      S_MUL:   if (cnt == 5'd31) state_nx = S_FIX;
      S_DIV:   if (cnt == 5'd31) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_nx     = cnt;
    acc_nx     = acc;
    opa_nx     = opa;
    opb_nx     = opb;
    neg_res_nx = neg_res;
    neg_rem_nx = neg_rem;
    is_div_nx  = is_div;
    hi_nx      = hi;
    lo_nx      = lo;
    done_nx    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (op_mul || op_div) begin
            cnt_nx     = '0;
            opa_nx     = a_mag;
            opb_nx     = b_mag;
            neg_res_nx = a_neg ^ b_neg;
            neg_rem_nx = a_neg;
            is_div_nx  = op_div;
            acc_nx     = op_div ? {32'd0, a_mag} : '0;
          end else if (op == OP_MTHI) begin
            hi_nx   = a;
            done_nx = 1'b1;
          end else if (op == OP_MTLO) begin
            lo_nx   = a;
            done_nx = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_nx = {mul_sum, acc[31:1]};
        opb_nx = opb >> 1;
        cnt_nx = cnt + 5'd1;
      end
      S_DIV: begin
        if (!rem_sub[32]) acc_nx = {rem_sub[31:0], acc[30:0], 1'b1};
        else              acc_nx = {acc[62:0], 1'b0};
        cnt_nx = cnt + 5'd1;
      end
      S_FIX: begin
        done_nx = 1'b1;
        if (is_div) begin
          if (opb == 32'd0) begin
            // Restore the original dividend from its magnitude and sign.
            hi_nx = neg_rem ? 32'd0 - opa : opa;
            lo_nx = '1;
          end else begin
            hi_nx = neg_rem ? 32'd0 - acc[63:32] : acc[63:32];
            lo_nx = neg_res ? 32'd0 - acc[31:0]  : acc[31:0];
          end
        end else begin
          hi_nx = prod[63:32];
          lo_nx = prod[31:0];
        end
      end
      default: ;
    endcase
  end

  assign busy_nx = (state_nx != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      is_div  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      acc     <= acc_nx;
      opa     <= opa_nx;
      opb     <= opb_nx;
      neg_res <= neg_res_nx;
      neg_rem <= neg_rem_nx;
      is_div  <= is_div_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Directed self-checking bench for mips_cpu_muldiv_ctrl.
module tb_mips_cpu_muldiv_ctrl;

  logic        clk, reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  mips_cpu_muldiv_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a mul/div op and follow it to completion; optionally pulse MTHI mid-flight.
  task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el,
                       input string tag, input bit disturb);
    int unsigned busy_cnt;
    busy_cnt = 0;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7; a = $urandom; b = $urandom;
    for (int n = 1; n <= 33; n++) begin
      if (busy) busy_cnt++;
      if (n == 32) begin
        chk({tag, "_hi_hold"}, hi, cur_hi);
        chk({tag, "_lo_hold"}, lo, cur_lo);
        chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
      end
      if (disturb && n == 10) begin
        start = 1'b1; op = 3'd4; a = 32'h0000DEAD;
      end
      @(posedge clk); #1;
      if (disturb && n == 10) begin
        start = 1'b0; op = 3'd7;
        chk({tag, "_mthi_ignored"}, hi, cur_hi);
      end
    end
    chk({tag, "_busy_cycles"}, busy_cnt, 32'd33);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    cur_hi = eh;
    cur_lo = el;
  endtask

  task automatic do_move(input logic [2:0] o, input logic [31:0] av, input string tag);
    start = 1'b1; op = o; a = av; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    if (o == 3'd4) cur_hi = av;
    else           cur_lo = av;
    chk({tag, "_hi"}, hi, cur_hi);
    chk({tag, "_lo"}, lo, cur_lo);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd7; a = '0; b = '0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    #9 reset = 1'b0;
    @(posedge clk); #1;

    do_op(3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg", 1'b0);
    @(posedge clk); #1;
    chk("done_pulse_clear", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1'b0);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg", 1'b0);
    do_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu", 1'b0);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_wrap", 1'b0);
    do_op(3'd2, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, "div_zero_neg", 1'b0);
    do_op(3'd3, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, "divu_zero", 1'b0);
    do_op(3'd0, 32'd2, 32'd3, 32'd0, 32'd6, "mult_busy_rej", 1'b1);

    do_move(3'd5, 32'h0000BEEF, "mtlo");
    @(posedge clk); #1;
    chk("mtlo_done_clear", {31'd0, done}, 32'd0);

    start = 1'b1; op = 3'd6; a = 32'h55555555; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    chk("op6_busy", {31'd0, busy}, 32'd0);
    chk("op6_done", {31'd0, done}, 32'd0);
    chk("op6_hi", hi, cur_hi);
    chk("op6_lo", lo, cur_lo);

    do_move(3'd4, 32'h00000001, "mthi_pre");
    do_move(3'd5, 32'h00000002, "mtlo_pre");

    start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    cur_hi = '0;
    cur_lo = '0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    do_op(3'd1, 32'd4, 32'd4, 32'd0, 32'd16, "multu_post_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
